mdu_engine: RTL and testbench

- Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi, mtlo and serves mfhi/mflo reads.
- Produces the start and busy signals the hazard controller uses to stall MDU-related instructions in D.
- Holds architectural HI/LO and iterates for a fixed latency per operation class.

---
 rtl/mdu_engine.sv | 170 +++++++++++++++++
 tb/tb_mdu_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_engine.sv
// mdu_engine: multiply/divide unit for the E stage of a five-stage MIPS pipeline.
// Owns architectural HI/LO, accepts mult/multu/div/divu/mthi/mtlo and serves
// mfhi/mflo reads. Arithmetic is evaluated once at the start edge and parked in
// a pending register; a down-counter models the fixed latency before HI/LO see it.
module mdu_engine #(
    parameter int MULT_CYCLES = 5,  // busy cycles for mult/multu (1..15)
    parameter int DIV_CYCLES  = 10  // busy cycles for div/divu (1..15)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic        is_mult_op;
    logic        is_div_op;
    logic        div_by_zero;
    logic [63:0] mul_s, mul_u;
    logic [31:0] a_mag, b_mag, b_safe_u, b_safe_mag;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic [63:0] result;

    assign is_mult_op  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op   = (op == OP_DIV)  || (op == OP_DIVU);
    assign div_by_zero = is_div_op && (B == 32'd0);

    assign busy  = (state_q == S_RUN);
    assign start = (is_mult_op || is_div_op) && !req && !busy;

    // Read port: HI/LO as they stand now, so mfhi/mflo during a run see old values.
    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI) begin
            out = hi_q;
        end else if (op == OP_MFLO) begin
            out = lo_q;
        end
    end

    // Products: explicit sign/zero extension keeps the 64-bit result exact.
    assign mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign mul_u = {32'd0, A} * {32'd0, B};

    // Divisors are forced to 1 on B=0 so the divider never sees zero; that
    // result is discarded because pend_we is cleared for divide-by-zero.
    assign a_mag      = A[31] ? (~A + 32'd1) : A;
    assign b_mag      = B[31] ? (~B + 32'd1) : B;
    assign b_safe_mag = (B == 32'd0) ? 32'd1 : b_mag;
    assign b_safe_u   = (B == 32'd0) ? 32'd1 : B;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
    // as 0x80000000 remainder 0.
    assign quo_mag = a_mag / b_safe_mag;
    assign rem_mag = a_mag % b_safe_mag;
    assign quo_s   = (A[31] ^ B[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s   = A[31] ? (~rem_mag + 32'd1) : rem_mag;
    assign quo_u   = A / b_safe_u;
    assign rem_u   = A % b_safe_u;

    // Select the 64-bit {HI, LO} result for the operation being started.
    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = mul_s;
            OP_MULTU: result = mul_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
            default:  result = 64'd0;
        endcase
    end

    // Next-state logic: start/mthi/mtlo in IDLE, count down and commit in RUN.
    // NOTE: every target gets its hold value first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_hi_d = result[63:32];
                    pend_lo_d = result[31:0];
                    pend_we_d = !div_by_zero;
                    cnt_d     = is_mult_op ? MULT_LAT : DIV_LAT;
                    state_d   = S_RUN;
                end else if (!req && (op == OP_MTHI)) begin
                    hi_d = A;
                end else if (!req && (op == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                // Ops 1..6 and req are ignored here: the running result belongs
                // to an older instruction and always completes.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any run without touching HI/LO
    // beyond clearing them.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

endmodule

// File: tb/tb_mdu_engine.sv
// Directed testbench for mdu_engine: inputs change and outputs are sampled
// around the falling edge, away from the active rising edge.
module tb_mdu_engine;

    logic        clk;
    logic        reset_n;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] out;

    int n_checks = 0;
    int n_errors = 0;

    mdu_engine #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .A       (A),
        .B       (B),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count falling edges while busy stays high, bounded so the run cannot hang.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        #1;
    endtask

    // Issue a start-class op at the next falling edge and step into the first busy cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; req = 1'b0;
        #1;
        n_checks++;
        if (start !== 1'b1) begin
            n_errors++;
            $display("FAIL issue_start op=%0d: start=%b expected 1", o, start);
        end
        @(negedge clk);
        op = 4'd0;
    endtask

    // Read HI and LO through out and compare against expected values.
    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        op = 4'd7; #1;
        n_checks++;
        if (out !== exp_hi) begin
            n_errors++;
            $display("FAIL %s_hi: out=%h expected %h", tag, out, exp_hi);
        end
        op = 4'd8; #1;
        n_checks++;
        if (out !== exp_lo) begin
            n_errors++;
            $display("FAIL %s_lo: out=%h expected %h", tag, out, exp_lo);
        end
        op = 4'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op = 4'd0; A = '0; B = '0; req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b start=%b expected 0 0", busy, start);
        end
        read_hilo("reset", 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        #1;
        n_checks++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mult_cycle1: start=%b busy=%b expected 0 1", start, busy);
        end
        wait_idle(n);
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL mult_latency: busy cycles=%0d expected 5", n);
        end
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    endtask

    task automatic test_multu();
        int n;
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        op = 4'd8; #1;
        n_checks++;
        if (out !== 32'hFFFF_FFFA) begin
            n_errors++;
            $display("FAIL multu_old_lo: out=%h expected fffffffa", out);
        end
        wait_idle(n);
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL multu_latency: busy cycles=%0d expected 5", n);
        end
        read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        int n;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        // Protocol violations while busy: mthi and a new mult must be ignored.
        op = 4'd5; A = 32'hDEAD_BEEF; #1;
        @(negedge clk);
        op = 4'd1; A = 32'd9; B = 32'd9; #1;
        n_checks++;
        if (start !== 1'b0) begin
            n_errors++;
            $display("FAIL div_busy_start: start=%b expected 0", start);
        end
        @(negedge clk);
        op = 4'd0;
        wait_idle(n);
        n_checks++;
        if (n != 8) begin
            n_errors++;
            $display("FAIL div_latency: remaining busy cycles=%0d expected 8", n);
        end
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(4'd4, 32'd7, 32'd0);
        wait_idle(n);
        n_checks++;
        if (n != 10) begin
            n_errors++;
            $display("FAIL divu0_latency: busy cycles=%0d expected 10", n);
        end
        read_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        read_hilo("divovf", 32'h0000_0000, 32'h8000_0000);

        issue(4'd4, 32'hFFFF_FFF9, 32'd16);
        wait_idle(n);
        read_hilo("divu", 32'h0000_0009, 32'h0FFF_FFFF);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        op = 4'd5; A = 32'h1234_5678; req = 1'b0;
        @(negedge clk);
        op = 4'd7; #1;
        n_checks++;
        if (out !== 32'h1234_5678 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mthi: out=%h busy=%b expected 12345678 0", out, busy);
        end
        op = 4'd6; A = 32'h0BAD_F00D;
        @(negedge clk);
        op = 4'd8; #1;
        n_checks++;
        if (out !== 32'h0BAD_F00D || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mtlo: out=%h busy=%b expected 0badf00d 0", out, busy);
        end
        op = 4'd5; A = 32'hAAAA_5555; req = 1'b1;
        @(negedge clk);
        op = 4'd6;
        @(negedge clk);
        req = 1'b0;
        read_hilo("mt_req", 32'h1234_5678, 32'h0BAD_F00D);
    endtask

    task automatic test_req();
        int n;
        @(negedge clk);
        op = 4'd1; A = 32'd5; B = 32'd7; req = 1'b1; #1;
        n_checks++;
        if (start !== 1'b0) begin
            n_errors++;
            $display("FAIL req_start: start=%b expected 0", start);
        end
        @(negedge clk);
        op = 4'd0; req = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL req_busy: busy=%b expected 0", busy);
        end
        issue(4'd1, 32'd5, 32'd7);
        @(negedge clk);
        req = 1'b1;
        wait_idle(n);
        req = 1'b0;
        n_checks++;
        if (n != 4) begin
            n_errors++;
            $display("FAIL req_run_latency: remaining busy cycles=%0d expected 4", n);
        end
        read_hilo("req_run", 32'h0, 32'h0000_0023);
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'd1, 32'd3, 32'd4);
        wait_idle(n);
        read_hilo("b2b_first", 32'h0, 32'h0000_000C);
        op = 4'd2; A = 32'h0001_0000; B = 32'h0001_0000; #1;
        n_checks++;
        if (start !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_start: start=%b expected 1", start);
        end
        @(negedge clk);
        op = 4'd0;
        wait_idle(n);
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL b2b_latency: busy cycles=%0d expected 5", n);
        end
        read_hilo("b2b_second", 32'h0000_0001, 32'h0000_0000);
    endtask

    task automatic test_reset_mid();
        int n;
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset_n = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_busy: busy=%b expected 0", busy);
        end
        read_hilo("rst_mid", 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(4'd1, 32'd6, 32'd7);
        wait_idle(n);
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL rst_mult_latency: busy cycles=%0d expected 5", n);
        end
        read_hilo("rst_mult", 32'h0, 32'h0000_002A);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_req();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
